// File: rtl/burst_sequencer.sv
// burst_sequencer: drives the compare input of one PWM channel in the phased-delay array.
// A burst configuration (start delay, duty, length) is latched through a valid/ready handshake.
// After a trigger, compare carries the duty for exactly the configured number of PWM periods.
// Every compare change lands on a PWM period boundary; the only exception is abort.
//
// Ports:
//   clk           system clock, shared with the pwm
//   rst_n         asynchronous active-low reset, shared with the pwm
//   i_cfg_valid   configuration offered
//   o_cfg_ready   configuration can be accepted (IDLE only)
//   i_cfg_delay   start delay in PWM periods
//   i_cfg_duty    high-time in clk cycles per period (clamped to PERIOD+1)
//   i_cfg_cycles  burst length in PWM periods
//   i_trigger     single-cycle start strobe
//   i_abort       immediate stop
//   o_compare     to pwm compare
//   o_busy        high in ARMED, DELAY and RUN
//   o_done        one-cycle pulse at normal burst completion
//   o_sync        one-cycle pulse while the period counter is 0
module burst_sequencer #(
  parameter int unsigned CW     = 11,
  parameter int unsigned PERIOD = 1250,
  parameter int unsigned DW     = 16,
  parameter int unsigned NW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [DW-1:0] i_cfg_delay,
  input  logic [CW-1:0] i_cfg_duty,
  input  logic [NW-1:0] i_cfg_cycles,
  input  logic          i_trigger,
  input  logic          i_abort,
  output logic [CW-1:0] o_compare,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sync
);

  localparam int unsigned PW = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
  localparam logic [PW-1:0] PeriodCnt = PW'(PERIOD);
  localparam logic [CW-1:0] FullDuty  = CW'(PERIOD + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StDelay, StRun} state_e;

  state_e        r_state;
  state_e        w_state_next;

  logic [PW-1:0] r_period_ctr;
  logic          r_sync;
  logic [DW-1:0] r_delay;
  logic [CW-1:0] r_duty;
  logic [NW-1:0] r_cycles;
  logic [DW-1:0] r_dcnt;
  logic [NW-1:0] r_ccnt;
  logic [CW-1:0] r_compare;
  logic          r_done;

  logic          w_boundary;
  logic          w_abort;
  logic          w_start;
  logic          w_finish;
  logic [CW-1:0] w_duty_clamped;

  assign w_boundary     = (r_period_ctr == PeriodCnt);
  // Abort only means something once a configuration has been taken.
  assign w_abort        = i_abort && (r_state != StIdle);
  assign w_start        = (r_state == StDelay) && w_boundary && (r_dcnt == '0);
  assign w_finish       = (r_state == StRun) && w_boundary && (r_ccnt == NW'(1));
  assign w_duty_clamped = (i_cfg_duty > FullDuty) ? FullDuty : i_cfg_duty;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (i_cfg_valid) w_state_next = StArmed;
        StArmed: if (i_trigger) w_state_next = StDelay;
        StDelay: if (w_start) w_state_next = (r_cycles == '0) ? StIdle : StRun;
        StRun:   if (w_finish) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    o_cfg_ready = (r_state == StIdle);
    o_busy      = (r_state != StIdle);
  end

  assign o_compare = r_compare;
  assign o_done    = r_done;
  assign o_sync    = r_sync;

  // Period counter and burst datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_ctr <= '0;
      r_sync       <= 1'b0;
      r_delay      <= '0;
      r_duty       <= '0;
      r_cycles     <= '0;
      r_dcnt       <= '0;
      r_ccnt       <= '0;
      r_compare    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_period_ctr <= w_boundary ? '0 : r_period_ctr + PW'(1);
      r_sync       <= w_boundary;
      r_done       <= 1'b0;
      if (w_abort) begin
        r_compare <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_cfg_valid) begin
              r_delay  <= i_cfg_delay;
              r_duty   <= w_duty_clamped;
              r_cycles <= i_cfg_cycles;
            end
          end
          StArmed: begin
            // A boundary in the trigger cycle is not counted: counting starts in DELAY.
            if (i_trigger) r_dcnt <= r_delay;
          end
          StDelay: begin
            if (w_start) begin
              if (r_cycles == '0) begin
                r_done <= 1'b1;
              end else begin
                r_compare <= r_duty;
                r_ccnt    <= r_cycles;
              end
            end else if (w_boundary) begin
              r_dcnt <= r_dcnt - DW'(1);
            end
          end
          StRun: begin
            if (w_finish) begin
              r_compare <= '0;
              r_done    <= 1'b1;
            end else if (w_boundary) begin
              r_ccnt <= r_ccnt - NW'(1);
            end
          end
          default: r_compare <= '0;
        endcase
      end
    end
  end

endmodule
